// File: rtl/serv_dbus_ctrl.sv
// Serial-to-parallel data bus controller: shifts store data in, runs a single
// bus cycle, then shifts the aligned and sign-extended load result back out.
module serv_dbus_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cnt_en,
  input  logic                      i_cnt_done,
  input  logic                      i_dbus_req,
  input  logic                      i_we,
  input  logic [1:0]                i_size,
  input  logic                      i_signed,
  input  logic [1:0]                i_lsb,
  input  logic [31:0]               i_adr,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  output logic [BITS_PER_CYCLE-1:0] o_q,
  output logic                      o_busy,
  output logic                      o_ack,
  output logic                      o_misalign,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic [3:0]                o_wb_sel,
  output logic                      o_wb_we,
  output logic                      o_wb_cyc,
  input  logic [31:0]               i_wb_rdt,
  input  logic                      i_wb_ack
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state;
  logic [31:0] dat;
  logic [4:0]  cnt;
  logic        sbit;
  logic [1:0]  lsb_r;
  logic [1:0]  size_r;
  logic        signed_r;

  logic [31:0] rdt_shift;
  logic        sign_bit;
  logic        data_beat;

  assign o_misalign = ((i_size == 2'b01) & i_lsb[0]) | (i_size[1] & (i_lsb != 2'b00));

  // Load data is moved down to bit 0 so it can be shifted out LSB first.
  assign rdt_shift = i_wb_rdt >> {lsb_r, 3'b000};
  assign sign_bit  = size_r[1] ? rdt_shift[31] : (size_r[0] ? rdt_shift[15] : rdt_shift[7]);

  // Beats past the access width carry the sign (or zero) fill instead of data.
  assign data_beat = size_r[1] | (size_r[0] ? !cnt[4] : (cnt[4:3] == 2'b00));

  always_comb begin
    o_q = '0;
    if (i_cnt_en)
      o_q = data_beat ? dat[BITS_PER_CYCLE-1:0] : {BITS_PER_CYCLE{sbit}};
  end

  always_comb begin
    o_wb_dat = dat;
    o_wb_sel = 4'b1111;
    if (!size_r[1]) begin
      if (size_r[0]) begin
        o_wb_dat = {2{dat[15:0]}};
        o_wb_sel = lsb_r[1] ? 4'b1100 : 4'b0011;
      end else begin
        o_wb_dat = {4{dat[7:0]}};
        o_wb_sel = 4'b0001 << lsb_r;
      end
    end
  end

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_wb_cyc <= 1'b0;
      o_busy   <= 1'b0;
      o_ack    <= 1'b0;
      o_wb_adr <= '0;
      o_wb_we  <= 1'b0;
      lsb_r    <= '0;
      size_r   <= '0;
      signed_r <= 1'b0;
      cnt      <= '0;
      sbit     <= 1'b0;
      dat      <= '0;
    end else begin
      o_ack <= 1'b0;
      if (i_cnt_done)
        cnt <= '0;
      else if (i_cnt_en)
        cnt <= cnt + 5'(BITS_PER_CYCLE);

      case (state)
        IDLE: begin
          if (i_cnt_en)
            dat <= {i_rs2, dat[31:BITS_PER_CYCLE]};
          if (i_dbus_req && !o_misalign) begin
            state    <= BUS;
            o_wb_cyc <= 1'b1;
            o_busy   <= 1'b1;
            o_wb_adr <= i_adr;
            o_wb_we  <= i_we;
            lsb_r    <= i_lsb;
            size_r   <= i_size;
            signed_r <= i_signed;
          end
        end
        BUS: begin
          // Requests arriving while a cycle is outstanding are dropped.
          if (i_wb_ack) begin
            state    <= IDLE;
            o_wb_cyc <= 1'b0;
            o_busy   <= 1'b0;
            o_ack    <= 1'b1;
            if (!o_wb_we) begin
              dat  <= rdt_shift;
              sbit <= signed_r & sign_bit;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
